// File: rtl/dmem_pkg.sv
// Shared types and helpers for the LSU-side data memory responder.
// Lane count, word width, FSM state encoding and byte-lane mask expansion.
package dmem_pkg;

    localparam int N_LANES = 4;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_st_t;

    // Expand a per-byte enable into a full-word bit mask.
    function automatic logic [WORD_W-1:0] lane_mask(input logic [N_LANES-1:0] lanes);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int k = 0; k < N_LANES; k++) begin
            m[8*k +: 8] = {8{lanes[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/u_dmem_ram.sv
// Single-port word SRAM model with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module u_dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH_W = 1024,
    parameter int AW      = $clog2(DEPTH_W)
) (
    input  logic                clk_i,
    input  logic [N_LANES-1:0]  we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [WORD_W-1:0]   wd_i,
    output logic [WORD_W-1:0]   rd_o
);

    logic [WORD_W-1:0] mem [DEPTH_W];
    logic [WORD_W-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < N_LANES; k++) begin
            if (we_i[k]) begin
                mem[addr_i][8*k +: 8] <= wd_i[8*k +: 8];
            end
        end
        rd_q <= mem[addr_i];
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/u_dmem.sv
// Data-memory responder for the LSU request bus: one-cycle byte-lane writes,
// reads returned after RD_LAT cycles with a combinational stall while in flight.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | accepting requests
//   WAIT  | read in flight, cnt_q counting down to 0
//   RESP  | lsu_vld cycle, inputs ignored
module u_dmem
    import dmem_pkg::*;
#(
    parameter int          DEPTH_W  = 1024,
    parameter int          RD_LAT   = 1,
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         lsu_a,
    input  logic [N_LANES-1:0]  lsu_we,
    input  logic [WORD_W-1:0]   lsu_wd,
    input  logic [N_LANES-1:0]  lsu_re,
    output logic                lsu_vld,
    output logic [WORD_W-1:0]   lsu_rd,
    output logic                lsu_busy,
    output logic                lsu_err
);

    localparam int         AW       = $clog2(DEPTH_W);
    localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    dmem_st_t            st_q, st_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [N_LANES-1:0]  mask_q, mask_d;
    logic                oor_q, oor_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   hold_q, hold_d;

    logic [31:0]         off;
    logic [AW-1:0]       idx;
    logic                oor;
    logic                wr;
    logic                rd;
    logic                unused_lo;

    logic [N_LANES-1:0]  ram_we;
    logic [AW-1:0]       ram_addr;
    logic [WORD_W-1:0]   ram_rd;
    logic [WORD_W-1:0]   rd_resp;

    // BASE_ADR is aligned to the array size, so the offset's upper bits flag overrun.
    assign off       = lsu_a - BASE_ADR;
    assign idx       = off[AW+1:2];
    assign oor       = (lsu_a < BASE_ADR) || (|off[31:AW+2]);
    assign unused_lo = ^off[1:0];
    assign wr        = |lsu_we;
    assign rd        = |lsu_re;

    // The live address feeds the RAM in IDLE so a one-cycle read is issued at the
    // request edge; afterwards the captured address keeps the read pointed at it.
    assign ram_addr = (st_q == IDLE) ? idx : adr_q;

    u_dmem_ram #(
        .DEPTH_W (DEPTH_W),
        .AW      (AW)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .wd_i   (lsu_wd),
        .rd_o   (ram_rd)
    );

    assign rd_resp = oor_q ? '0 : (ram_rd & lane_mask(mask_q));

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        adr_d  = adr_q;
        mask_d = mask_q;
        oor_d  = oor_q;
        hold_d = hold_q;
        err_d  = 1'b0;
        ram_we = '0;
        unique case (st_q)
            IDLE: begin
                if (wr) begin
                    ram_we = oor ? '0 : lsu_we;
                    err_d  = oor | rd;
                end else if (rd) begin
                    adr_d  = idx;
                    mask_d = lsu_re;
                    oor_d  = oor;
                    cnt_d  = CNT_INIT;
                    st_d   = (RD_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    st_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                hold_d = rd_resp;
                st_d   = IDLE;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= 2'd0;
            adr_q  <= '0;
            mask_q <= '0;
            oor_q  <= 1'b0;
            err_q  <= 1'b0;
            hold_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            adr_q  <= adr_d;
            mask_q <= mask_d;
            oor_q  <= oor_d;
            err_q  <= err_d;
            hold_q <= hold_d;
        end
    end

    assign lsu_vld  = (st_q == RESP);
    assign lsu_rd   = lsu_vld ? rd_resp : hold_q;
    assign lsu_err  = err_q | (lsu_vld & oor_q);
    assign lsu_busy = ((st_q == IDLE) && rd && !wr) || (st_q == WAIT);

endmodule
